// File: rtl/cam_capture_px.sv
// Camera byte-stream capture: assembles pixels, converts to RGB888 and
// generates linear frame-buffer writes with frame/line bookkeeping.
module cam_capture_px #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned BYTES_PER_PIX = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [23:0]       data_out,
    output logic              write_en,
    output logic              frame_done,
    output logic              line_err,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned X_W   = $clog2(H_ACTIVE + 2);
    localparam int unsigned Y_W   = $clog2(V_ACTIVE + 1);
    localparam int unsigned X_MAX = H_ACTIVE + 1;

    logic           v_q, h_q, v_d, h_d;
    logic [7:0]     d_q, b0;
    logic [1:0]     mode_q;
    logic           phase;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           armed;
    logic           wrote;

    logic           pix_done_c, in_win_c, wr_c, line_end_c, v_rise_c, frame_end_c;
    logic [23:0]    rgb_c;

    // Capture is gated by armed so a reset mid-frame waits for the next vsync.
    always_comb begin
        pix_done_c  = armed && !v_q && h_q &&
                      ((mode_q == 2'd3) || (phase == 1'(BYTES_PER_PIX - 1)));
        in_win_c    = (x < X_W'(H_ACTIVE)) && (y < Y_W'(V_ACTIVE));
        wr_c        = pix_done_c && in_win_c;
        line_end_c  = armed && !v_q && h_d && !h_q;
        v_rise_c    = v_q && !v_d;
        frame_end_c = v_rise_c && wrote;
    end

    // Pixel format conversion; current byte d_q acts as byte 1.
    always_comb begin
        rgb_c = 24'd0;
        case (mode_q)
            2'd0: rgb_c = {b0[7:3], b0[7:5],
                           b0[2:0], d_q[7:5], b0[2:1],
                           d_q[4:0], d_q[4:2]};
            2'd1: rgb_c = {b0[3:0], b0[3:0], d_q[7:4], d_q[7:4], d_q[3:0], d_q[3:0]};
            2'd2: rgb_c = {b0, b0, b0};
            default: rgb_c = {d_q, d_q, d_q};
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            v_q        <= 1'b0;
            h_q        <= 1'b0;
            v_d        <= 1'b0;
            h_d        <= 1'b0;
            d_q        <= 8'd0;
            b0         <= 8'd0;
            mode_q     <= 2'd0;
            phase      <= 1'b0;
            x          <= '0;
            y          <= '0;
            armed      <= 1'b0;
            wrote      <= 1'b0;
            addr       <= '0;
            data_out   <= 24'd0;
            write_en   <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            v_q        <= vsync;
            h_q        <= href;
            d_q        <= data;
            v_d        <= v_q;
            h_d        <= h_q;
            write_en   <= wr_c;
            frame_done <= frame_end_c;

            if (wr_c)
                data_out <= rgb_c;

            if (frame_end_c)
                frame_cnt <= frame_cnt + 16'd1;

            if (v_rise_c)
                wrote <= 1'b0;
            else if (wr_c)
                wrote <= 1'b1;

            // Set wins; clear lands the cycle after frame_done so both are seen together.
            if (line_end_c && (x != X_W'(H_ACTIVE)))
                line_err <= 1'b1;
            else if (frame_done)
                line_err <= 1'b0;

            if (v_q) begin
                mode_q <= mode;
                armed  <= 1'b1;
                phase  <= 1'b0;
                x      <= '0;
                y      <= '0;
                addr   <= '0;
            end else begin
                if (write_en)
                    addr <= addr + ADDR_W'(1);

                if (!h_q || pix_done_c) begin
                    phase <= 1'b0;
                end else if (armed) begin
                    b0    <= d_q;
                    phase <= phase + 1'b1;
                end

                if (line_end_c) begin
                    x <= '0;
                    if (y != Y_W'(V_ACTIVE))
                        y <= y + Y_W'(1);
                end else if (pix_done_c && (x != X_W'(X_MAX))) begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

endmodule
